uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, 1-2 stop bits.
// TX, BUSY and TX_DONE are registered; the next line level is computed from the next state.
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  input  logic [31:0]           PARITY_TYPE,
  input  logic                  PARITY_IN,
  output logic                  DATA_READY,
  output logic                  TX,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] StopLast = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign DATA_READY = (state_q == StIdle);
  assign TX         = tx_q;
  assign BUSY       = busy_q;
  assign TX_DONE    = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    bit_end   = (cnt_q == CntLast);

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (DATA_VALID) begin
          state_d   = StStart;
          cnt_d     = '0;
          idx_d     = '0;
          data_d    = DATA_IN;
          par_en_d  = (PARITY_TYPE >= 32'd1) && (PARITY_TYPE <= 32'd4);
          // Mark/space override the upstream parity bit.
          par_bit_d = (PARITY_TYPE == 32'd3) ? 1'b1 :
                      (PARITY_TYPE == 32'd4) ? 1'b0 : PARITY_IN;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        // idx is reused to count stop bits.
        if (bit_end) begin
          if (idx_q == StopLast) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_q[idx_d];
      StParity: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_q == StStop) && (state_d == StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
